// File: rtl/age_issue_queue_if.sv
// Dispatch, wakeup and issue signal bundle for the age-ordered issue queue.
// master drives dispatch/wakeup/issue_ready; slave is the queue itself.
interface age_issue_queue_if #(
    parameter int NUM_ENTRIES    = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int WAKEUP_PORTS   = 2,
    parameter int PHY_REGS       = 64,
    parameter int ROB_WIDTH      = 4,
    parameter int PAYLOAD_W      = 64
);
    localparam int PRW = $clog2(PHY_REGS);
    localparam int CW  = $clog2(NUM_ENTRIES) + 1;

    logic [DISPATCH_WIDTH-1:0]           disp_valid;
    logic [DISPATCH_WIDTH*ROB_WIDTH-1:0] disp_rob_id;
    logic [DISPATCH_WIDTH*PRW-1:0]       disp_src1;
    logic [DISPATCH_WIDTH*PRW-1:0]       disp_src2;
    logic [DISPATCH_WIDTH-1:0]           disp_src1_used;
    logic [DISPATCH_WIDTH-1:0]           disp_src2_used;
    logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] disp_payload;
    logic                                dispatch_ready;
    logic [CW-1:0]                       free_count;
    logic [PHY_REGS-1:0]                 PRF_valid;
    logic [WAKEUP_PORTS-1:0]             wake_valid;
    logic [WAKEUP_PORTS*PRW-1:0]         wake_tag;
    logic                                issue_valid;
    logic                                issue_ready;
    logic [ROB_WIDTH-1:0]                issue_rob_id;
    logic [PRW-1:0]                      issue_src1;
    logic [PRW-1:0]                      issue_src2;
    logic [PAYLOAD_W-1:0]                issue_payload;

    modport master (
        output disp_valid, disp_rob_id, disp_src1, disp_src2, disp_src1_used,
               disp_src2_used, disp_payload, PRF_valid, wake_valid, wake_tag, issue_ready,
        input  dispatch_ready, free_count, issue_valid, issue_rob_id, issue_src1,
               issue_src2, issue_payload
    );

    modport slave (
        input  disp_valid, disp_rob_id, disp_src1, disp_src2, disp_src1_used,
               disp_src2_used, disp_payload, PRF_valid, wake_valid, wake_tag, issue_ready,
        output dispatch_ready, free_count, issue_valid, issue_rob_id, issue_src1,
               issue_src2, issue_payload
    );
endinterface

// File: rtl/age_issue_queue.sv
// Age-matrix issue queue: oldest ready entry goes to the issue register two edges after dispatch.
// Issue register holds while issue_ready=0; dispatch is dropped whole when dispatch_ready=0.
module age_issue_queue #(
    parameter int NUM_ENTRIES    = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int WAKEUP_PORTS   = 2,
    parameter int PHY_REGS       = 64,
    parameter int ROB_WIDTH      = 4,
    parameter int PAYLOAD_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    age_issue_queue_if.slave  q
);
    localparam int PRW = $clog2(PHY_REGS);
    localparam int IW  = $clog2(NUM_ENTRIES);
    localparam int CW  = IW + 1;

    logic [NUM_ENTRIES-1:0]                  valid, rdy1, rdy2, eligible, free_v;
    logic [ROB_WIDTH-1:0]                    rob_id  [NUM_ENTRIES];
    logic [PRW-1:0]                          src1    [NUM_ENTRIES];
    logic [PRW-1:0]                          src2    [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]                    payload [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older, older_nxt;
    logic [CW-1:0]                           free_count, n_alloc;
    logic [PHY_REGS-1:0]                     reg_ready;
    logic [DISPATCH_WIDTH-1:0]               alloc_en;
    logic [IW-1:0]                           alloc_idx [DISPATCH_WIDTH];
    logic [IW-1:0]                           sel_idx;
    logic                                    sel_any, blocked, do_issue, dispatch_ready;
    logic                                    issue_valid;
    logic [ROB_WIDTH-1:0]                    issue_rob_id;
    logic [PRW-1:0]                          issue_src1, issue_src2;
    logic [PAYLOAD_W-1:0]                    issue_payload;

    assign dispatch_ready   = (free_count >= CW'(DISPATCH_WIDTH));
    assign q.dispatch_ready = dispatch_ready;
    assign q.free_count     = free_count;
    assign q.issue_valid    = issue_valid;
    assign q.issue_rob_id   = issue_rob_id;
    assign q.issue_src1     = issue_src1;
    assign q.issue_src2     = issue_src2;
    assign q.issue_payload  = issue_payload;

    // Register-ready view for this cycle: PRF state merged with same-cycle broadcasts.
    always_comb begin
        reg_ready = q.PRF_valid;
        for (int k = 0; k < WAKEUP_PORTS; k++)
            if (q.wake_valid[k]) reg_ready[q.wake_tag[k*PRW +: PRW]] = 1'b1;
    end

    // Oldest eligible: no other eligible entry is marked older than it.
    always_comb begin
        eligible = valid & rdy1 & rdy2;
        sel_any  = 1'b0;
        sel_idx  = '0;
        blocked  = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++)
                blocked = blocked | (eligible[j] & older[j][i]);
            if (eligible[i] && !blocked) begin
                sel_any = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    assign do_issue = sel_any & (!issue_valid | q.issue_ready);

    always_comb begin
        free_v  = ~valid;
        n_alloc = '0;
        for (int p = 0; p < DISPATCH_WIDTH; p++) begin
            alloc_en[p]  = 1'b0;
            alloc_idx[p] = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (dispatch_ready && q.disp_valid[p] && free_v[i] && !alloc_en[p]) begin
                    alloc_en[p]  = 1'b1;
                    alloc_idx[p] = IW'(i);
                end
            end
            if (alloc_en[p]) free_v[alloc_idx[p]] = 1'b0;
            n_alloc = n_alloc + CW'(alloc_en[p]);
        end
    end

    // New entries are younger than all residents and than lower-port newcomers.
    always_comb begin
        older_nxt = older;
        for (int p = 0; p < DISPATCH_WIDTH; p++) begin
            if (alloc_en[p]) begin
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    older_nxt[alloc_idx[p]][j] = 1'b0;
                    older_nxt[j][alloc_idx[p]] = valid[j];
                end
            end
        end
        for (int p = 1; p < DISPATCH_WIDTH; p++)
            for (int r = 0; r < p; r++)
                if (alloc_en[p] && alloc_en[r]) older_nxt[alloc_idx[r]][alloc_idx[p]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            rdy1          <= '0;
            rdy2          <= '0;
            older         <= '0;
            free_count    <= CW'(NUM_ENTRIES);
            issue_valid   <= 1'b0;
            issue_rob_id  <= '0;
            issue_src1    <= '0;
            issue_src2    <= '0;
            issue_payload <= '0;
        end else if (flush) begin
            valid       <= '0;
            issue_valid <= 1'b0;
            free_count  <= CW'(NUM_ENTRIES);
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (valid[i]) begin
                    rdy1[i] <= rdy1[i] | reg_ready[src1[i]];
                    rdy2[i] <= rdy2[i] | reg_ready[src2[i]];
                end
            end
            for (int p = 0; p < DISPATCH_WIDTH; p++) begin
                if (alloc_en[p]) begin
                    valid[alloc_idx[p]]   <= 1'b1;
                    rob_id[alloc_idx[p]]  <= q.disp_rob_id[p*ROB_WIDTH +: ROB_WIDTH];
                    src1[alloc_idx[p]]    <= q.disp_src1[p*PRW +: PRW];
                    src2[alloc_idx[p]]    <= q.disp_src2[p*PRW +: PRW];
                    payload[alloc_idx[p]] <= q.disp_payload[p*PAYLOAD_W +: PAYLOAD_W];
                    rdy1[alloc_idx[p]]    <= !q.disp_src1_used[p] | reg_ready[q.disp_src1[p*PRW +: PRW]];
                    rdy2[alloc_idx[p]]    <= !q.disp_src2_used[p] | reg_ready[q.disp_src2[p*PRW +: PRW]];
                end
            end
            older <= older_nxt;
            if (do_issue) begin
                valid[sel_idx] <= 1'b0;
                issue_valid    <= 1'b1;
                issue_rob_id   <= rob_id[sel_idx];
                issue_src1     <= src1[sel_idx];
                issue_src2     <= src2[sel_idx];
                issue_payload  <= payload[sel_idx];
            end else if (q.issue_ready) begin
                issue_valid <= 1'b0;
            end
            free_count <= free_count - n_alloc + CW'(do_issue);
        end
    end
endmodule

// File: tb/tb_age_issue_queue.sv
// Scenario bench for age_issue_queue: inline timing checks plus an issue-order scoreboard.
module tb_age_issue_queue;
    localparam int N = 8, DW = 2, WP = 2, PR = 64, RW = 4, PW = 64, PRW = 6;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    age_issue_queue_if #(.NUM_ENTRIES(N), .DISPATCH_WIDTH(DW), .WAKEUP_PORTS(WP),
                         .PHY_REGS(PR), .ROB_WIDTH(RW), .PAYLOAD_W(PW)) bus ();

    age_issue_queue #(.NUM_ENTRIES(N), .DISPATCH_WIDTH(DW), .WAKEUP_PORTS(WP),
                      .PHY_REGS(PR), .ROB_WIDTH(RW), .PAYLOAD_W(PW))
        dut (.clk(clk), .rst(rst), .flush(flush), .q(bus));

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [PW-1:0] pl;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;

    function automatic logic [PW-1:0] pl_of(input logic [RW-1:0] rob);
        return {16{rob}} ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_valid     = '0;
        bus.disp_rob_id    = '0;
        bus.disp_src1      = '0;
        bus.disp_src2      = '0;
        bus.disp_src1_used = '0;
        bus.disp_src2_used = '0;
        bus.disp_payload   = '0;
        bus.wake_valid     = '0;
        bus.wake_tag       = '0;
    endtask

    task automatic set_port(input int p, input logic [RW-1:0] rob, input logic [PRW-1:0] s1,
                            input logic u1, input logic [PRW-1:0] s2, input logic u2);
        bus.disp_valid[p]               = 1'b1;
        bus.disp_rob_id[p*RW +: RW]     = rob;
        bus.disp_src1[p*PRW +: PRW]     = s1;
        bus.disp_src2[p*PRW +: PRW]     = s2;
        bus.disp_src1_used[p]           = u1;
        bus.disp_src2_used[p]           = u2;
        bus.disp_payload[p*PW +: PW]    = pl_of(rob);
    endtask

    task automatic push_exp(input logic [RW-1:0] rob);
        exp_t e;
        e.rob = rob;
        e.pl  = pl_of(rob);
        sb.push_back(e);
    endtask

    // Every accepted issue is matched against the expected order.
    always @(negedge clk) begin
        if (!rst && !flush && bus.issue_valid && bus.issue_ready) begin
            exp_t e;
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected: got rob %0d, required no issue", bus.issue_rob_id);
            end else begin
                e = sb.pop_front();
                if (bus.issue_rob_id !== e.rob || bus.issue_payload !== e.pl) begin
                    fails++;
                    $display("FAIL issue_order: got rob %0d payload %h, required rob %0d payload %h",
                             bus.issue_rob_id, bus.issue_payload, e.rob, e.pl);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests_run++; if (bus.free_count !== 4'd8) begin fails++; $display("FAIL reset_fc: got %0d, required 8", bus.free_count); end
        tests_run++; if (bus.dispatch_ready !== 1'b1) begin fails++; $display("FAIL reset_drdy: got %b, required 1", bus.dispatch_ready); end
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL reset_ivld: got %b, required 0", bus.issue_valid); end
        tests_run++; if (bus.issue_rob_id !== 4'd0) begin fails++; $display("FAIL reset_rob: got %0d, required 0", bus.issue_rob_id); end
        tests_run++; if (bus.issue_payload !== 64'd0) begin fails++; $display("FAIL reset_payload: got %h, required 0", bus.issue_payload); end
    endtask

    task automatic test_back_to_back();
        bus.issue_ready = 1'b1;
        set_port(0, 4'd3, 6'd0, 1'b0, 6'd0, 1'b0);
        set_port(1, 4'd4, 6'd0, 1'b0, 6'd0, 1'b0);
        push_exp(4'd3);
        push_exp(4'd4);
        step();
        idle_inputs();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL b2b_t0_vld: got %b, required 0", bus.issue_valid); end
        tests_run++; if (bus.free_count !== 4'd6) begin fails++; $display("FAIL b2b_t0_fc: got %0d, required 6", bus.free_count); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd3) begin fails++; $display("FAIL b2b_t1: got vld %b rob %0d, required vld 1 rob 3", bus.issue_valid, bus.issue_rob_id); end
        tests_run++; if (bus.free_count !== 4'd7) begin fails++; $display("FAIL b2b_t1_fc: got %0d, required 7", bus.free_count); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd4) begin fails++; $display("FAIL b2b_t2: got vld %b rob %0d, required vld 1 rob 4", bus.issue_valid, bus.issue_rob_id); end
        tests_run++; if (bus.free_count !== 4'd8) begin fails++; $display("FAIL b2b_t2_fc: got %0d, required 8", bus.free_count); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL b2b_t3_vld: got %b, required 0", bus.issue_valid); end
    endtask

    task automatic test_wakeup_order();
        set_port(0, 4'd1, 6'd12, 1'b1, 6'd0, 1'b0);
        set_port(1, 4'd2, 6'd0, 1'b0, 6'd0, 1'b0);
        push_exp(4'd2);
        push_exp(4'd1);
        step();
        idle_inputs();
        step();
        tests_run++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd2) begin fails++; $display("FAIL wake_young_first: got vld %b rob %0d, required vld 1 rob 2", bus.issue_valid, bus.issue_rob_id); end
        bus.wake_valid[0]     = 1'b1;
        bus.wake_tag[0 +: PRW] = 6'd12;
        step();
        idle_inputs();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL wake_gap: got %b, required 0", bus.issue_valid); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd1) begin fails++; $display("FAIL wake_old_next: got vld %b rob %0d, required vld 1 rob 1", bus.issue_valid, bus.issue_rob_id); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL wake_drain: got %b, required 0", bus.issue_valid); end
    endtask

    task automatic test_same_cycle_wake();
        set_port(0, 4'd5, 6'd0, 1'b0, 6'd20, 1'b1);
        bus.wake_valid[1]        = 1'b1;
        bus.wake_tag[PRW +: PRW] = 6'd20;
        push_exp(4'd5);
        step();
        idle_inputs();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL scw_t0: got %b, required 0", bus.issue_valid); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd5) begin fails++; $display("FAIL scw_t1: got vld %b rob %0d, required vld 1 rob 5", bus.issue_valid, bus.issue_rob_id); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL scw_drain: got %b, required 0", bus.issue_valid); end
    endtask

    task automatic test_fill();
        int k;
        for (int c = 0; c < 4; c++) begin
            set_port(0, 4'(8 + 2*c), 6'd30, 1'b1, 6'd0, 1'b0);
            set_port(1, 4'(9 + 2*c), 6'd30, 1'b1, 6'd0, 1'b0);
            step();
        end
        idle_inputs();
        tests_run++; if (bus.free_count !== 4'd0) begin fails++; $display("FAIL fill_fc: got %0d, required 0", bus.free_count); end
        tests_run++; if (bus.dispatch_ready !== 1'b0) begin fails++; $display("FAIL fill_drdy: got %b, required 0", bus.dispatch_ready); end
        set_port(0, 4'd1, 6'd0, 1'b0, 6'd0, 1'b0);
        set_port(1, 4'd2, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        tests_run++; if (bus.free_count !== 4'd0) begin fails++; $display("FAIL full_drop_fc: got %0d, required 0", bus.free_count); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL full_hold_vld: got %b, required 0", bus.issue_valid); end
        for (int r = 8; r < 16; r++) push_exp(4'(r));
        bus.PRF_valid[30] = 1'b1;
        step();
        bus.PRF_valid[30] = 1'b0;
        k = 0;
        while (k < 30 && !(bus.free_count == 4'd8 && bus.issue_valid == 1'b0)) begin
            step();
            k++;
        end
        tests_run++; if (bus.free_count !== 4'd8 || bus.issue_valid !== 1'b0) begin fails++; $display("FAIL fill_drain: got fc %0d vld %b after %0d cycles, required fc 8 vld 0", bus.free_count, bus.issue_valid, k); end
    endtask

    task automatic test_stall();
        bus.issue_ready = 1'b0;
        set_port(0, 4'd6, 6'd0, 1'b0, 6'd0, 1'b0);
        set_port(1, 4'd7, 6'd0, 1'b0, 6'd0, 1'b0);
        push_exp(4'd6);
        push_exp(4'd7);
        step();
        idle_inputs();
        tests_run++; if (bus.free_count !== 4'd6) begin fails++; $display("FAIL stall_t0_fc: got %0d, required 6", bus.free_count); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd6) begin fails++; $display("FAIL stall_load: got vld %b rob %0d, required vld 1 rob 6", bus.issue_valid, bus.issue_rob_id); end
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd6 || bus.issue_payload !== pl_of(4'd6) || bus.free_count !== 4'd7) begin
                fails++;
                $display("FAIL stall_hold%0d: got vld %b rob %0d fc %0d, required vld 1 rob 6 fc 7", c, bus.issue_valid, bus.issue_rob_id, bus.free_count);
            end
        end
        bus.issue_ready = 1'b1;
        step();
        tests_run++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd7 || bus.free_count !== 4'd8) begin fails++; $display("FAIL stall_release: got vld %b rob %0d fc %0d, required vld 1 rob 7 fc 8", bus.issue_valid, bus.issue_rob_id, bus.free_count); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL stall_drain: got %b, required 0", bus.issue_valid); end
    endtask

    task automatic test_flush();
        bus.issue_ready = 1'b0;
        set_port(0, 4'd9, 6'd0, 1'b0, 6'd0, 1'b0);
        set_port(1, 4'd10, 6'd40, 1'b1, 6'd0, 1'b0);
        step();
        set_port(0, 4'd11, 6'd40, 1'b1, 6'd0, 1'b0);
        set_port(1, 4'd12, 6'd40, 1'b1, 6'd0, 1'b0);
        step();
        set_port(0, 4'd13, 6'd40, 1'b1, 6'd0, 1'b0);
        set_port(1, 4'd14, 6'd40, 1'b1, 6'd0, 1'b0);
        step();
        idle_inputs();
        tests_run++; if (bus.free_count !== 4'd3 || bus.issue_valid !== 1'b1 || bus.issue_rob_id !== 4'd9) begin fails++; $display("FAIL preflush: got fc %0d vld %b rob %0d, required fc 3 vld 1 rob 9", bus.free_count, bus.issue_valid, bus.issue_rob_id); end
        flush = 1'b1;
        set_port(0, 4'd1, 6'd0, 1'b0, 6'd0, 1'b0);
        set_port(1, 4'd2, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        flush = 1'b0;
        idle_inputs();
        tests_run++; if (bus.free_count !== 4'd8 || bus.issue_valid !== 1'b0) begin fails++; $display("FAIL flush_state: got fc %0d vld %b, required fc 8 vld 0", bus.free_count, bus.issue_valid); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b0 || bus.free_count !== 4'd8) begin fails++; $display("FAIL flush_no_disp: got fc %0d vld %b, required fc 8 vld 0", bus.free_count, bus.issue_valid); end
        bus.issue_ready   = 1'b1;
        bus.PRF_valid[40] = 1'b1;
        step();
        bus.PRF_valid[40] = 1'b0;
        step();
        step();
        tests_run++; if (bus.issue_valid !== 1'b0 || bus.free_count !== 4'd8) begin fails++; $display("FAIL flush_gone: got fc %0d vld %b, required fc 8 vld 0", bus.free_count, bus.issue_valid); end
    endtask

    task automatic test_reset_mid();
        bus.issue_ready = 1'b1;
        set_port(0, 4'd3, 6'd0, 1'b0, 6'd0, 1'b0);
        set_port(1, 4'd5, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if (bus.free_count !== 4'd8 || bus.dispatch_ready !== 1'b1) begin fails++; $display("FAIL midrst_fc: got fc %0d drdy %b, required fc 8 drdy 1", bus.free_count, bus.dispatch_ready); end
        tests_run++; if (bus.issue_valid !== 1'b0 || bus.issue_rob_id !== 4'd0) begin fails++; $display("FAIL midrst_issue: got vld %b rob %0d, required vld 0 rob 0", bus.issue_valid, bus.issue_rob_id); end
        step();
        tests_run++; if (bus.issue_valid !== 1'b0) begin fails++; $display("FAIL midrst_after: got %b, required 0", bus.issue_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.PRF_valid   = '0;
        bus.issue_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_wakeup_order();
        test_same_cycle_wake();
        test_fill();
        test_stall();
        test_flush();
        test_reset_mid();
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
